// File: rtl/hms_bcd_counter_if.sv
// rtl/hms_bcd_counter_if.sv - control pulses and time/display bus of the time-of-day counter
interface hms_bcd_counter_if;
  logic       i_mode;
  logic       i_inc;
  logic [3:0] o_hour10;
  logic [3:0] o_hour0;
  logic [3:0] o_min10;
  logic [3:0] o_min0;
  logic [3:0] o_sec10;
  logic [3:0] o_sec0;
  logic [5:0] o_digit_blank;
  logic       o_tick;
  logic [1:0] o_mode;

  // Front-panel/controller side: issues pulses, consumes the digits.
  modport master (
    output i_mode, i_inc,
    input  o_hour10, o_hour0, o_min10, o_min0, o_sec10, o_sec0,
    input  o_digit_blank, o_tick, o_mode
  );

  // Counter side.
  modport slave (
    input  i_mode, i_inc,
    output o_hour10, o_hour0, o_min10, o_min0, o_sec10, o_sec0,
    output o_digit_blank, o_tick, o_mode
  );
endinterface

// File: rtl/hms_bcd_counter.sv
// rtl/hms_bcd_counter.sv - 24 h BCD time-of-day counter with 1 Hz prescaler, set-mode FSM and blink masks
module hms_bcd_counter #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  hms_bcd_counter_if.slave   bus
);

  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [7:0]    hour_q, hour_d;   // {tens, units} BCD
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic          tick_q, tick_d;
  logic [5:0]    blank_q, blank_d;

  // Minutes and seconds share the same 00..59 BCD rollover.
  function automatic logic [7:0] inc_bcd59(input logic [7:0] v);
    if (v[3:0] != 4'd9)      return {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5) return {v[7:4] + 4'd1, 4'd0};
    else                     return 8'h00;
  endfunction

  // Hours roll 23 -> 00; otherwise plain two-digit BCD increment.
  function automatic logic [7:0] inc_bcd23(input logic [7:0] v);
    if (v == 8'h23)          return 8'h00;
    else if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
    else                     return {v[7:4] + 4'd1, 4'd0};
  endfunction

  // Next state: mode FSM, prescaler, time increment, blink counter and blank mask.
  always_comb begin
    state_d     = state_q;
    presc_d     = '0;
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    tick_d      = 1'b0;
    blank_d     = 6'b000000;

    case (state_q)
      ST_RUN: begin
        // i_inc is ignored here; a mode pulse suppresses a coincident tick.
        if (bus.i_mode) begin
          state_d = ST_SET_HOUR;
        end else if (presc_q == PRESC_MAX) begin
          tick_d = 1'b1;
          if (sec_q == 8'h59) begin
            sec_d = 8'h00;
            if (min_q == 8'h59) begin
              min_d  = 8'h00;
              hour_d = inc_bcd23(hour_q);
            end else begin
              min_d = inc_bcd59(min_q);
            end
          end else begin
            sec_d = inc_bcd59(sec_q);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      ST_SET_HOUR, ST_SET_MIN: begin
        if (bus.i_mode) begin
          if (state_q == ST_SET_HOUR) begin
            state_d = ST_SET_MIN;
          end else begin
            state_d = ST_RUN;
            sec_d   = 8'h00;
          end
        end else if (bus.i_inc) begin
          // Adjusting keeps the field steadily visible: blink restarts from phase 0.
          if (state_q == ST_SET_HOUR) hour_d = inc_bcd23(hour_q);
          else                        min_d  = inc_bcd59(min_q);
        end else if (blink_cnt_q == BLINK_MAX) begin
          phase_d = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
          phase_d     = phase_q;
        end
      end

      default: state_d = ST_RUN;
    endcase

    case (state_d)
      ST_SET_HOUR: blank_d = {phase_d, phase_d, 4'b0000};
      ST_SET_MIN:  blank_d = {2'b00, phase_d, phase_d, 2'b00};
      default:     blank_d = 6'b000000;
    endcase
  end

  // State and output registers; reset aborts any mode immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      hour_q      <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      tick_q      <= 1'b0;
      blank_q     <= 6'b000000;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tick_q      <= tick_d;
      blank_q     <= blank_d;
    end
  end

  assign bus.o_hour10      = hour_q[7:4];
  assign bus.o_hour0       = hour_q[3:0];
  assign bus.o_min10       = min_q[7:4];
  assign bus.o_min0        = min_q[3:0];
  assign bus.o_sec10       = sec_q[7:4];
  assign bus.o_sec0        = sec_q[3:0];
  assign bus.o_digit_blank = blank_q;
  assign bus.o_tick        = tick_q;
  assign bus.o_mode        = state_q;

endmodule

// File: tb/tb_hms_bcd_counter.sv
// tb/tb_hms_bcd_counter.sv - directed self-checking bench for hms_bcd_counter
module tb_hms_bcd_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tick_cnt = 0;

  always #5 clk = ~clk;

  hms_bcd_counter_if bus();

  hms_bcd_counter #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Running count of o_tick pulses, sampled mid-cycle.
  always @(negedge clk) if (bus.o_tick === 1'b1) tick_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hms();
    return {8'h00, bus.o_hour10, bus.o_hour0, bus.o_min10, bus.o_min0, bus.o_sec10, bus.o_sec0};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic m, input logic inc);
    bus.i_mode = m;
    bus.i_inc  = inc;
    step(1);
    bus.i_mode = 1'b0;
    bus.i_inc  = 1'b0;
  endtask

  initial begin
    int ticks;
    int first;
    int last;
    int bad_gap;
    int t0;

    bus.i_mode = 1'b0;
    bus.i_inc  = 1'b0;
    step(3);
    check_eq("rst_time",  hms(), 32'h000000);
    check_eq("rst_mode",  {30'd0, bus.o_mode}, 32'd0);
    check_eq("rst_blank", {26'd0, bus.o_digit_blank}, 32'd0);
    check_eq("rst_tick",  {31'd0, bus.o_tick}, 32'd0);

    // Free run for 40 cycles: ten ticks, four cycles apart, the first on cycle 4.
    rst_n = 1'b1;
    ticks = 0; first = 0; last = 0; bad_gap = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (bus.o_tick === 1'b1) begin
        ticks++;
        if (ticks == 1) first = k;
        else if (k - last != 4) bad_gap++;
        last = k;
      end
    end
    check_eq("run_first_tick", first, 4);
    check_eq("run_tick_count", ticks, 10);
    check_eq("run_tick_gaps", bad_gap, 0);
    check_eq("run_time_10s", hms(), 32'h000010);
    check_eq("run_blank", {26'd0, bus.o_digit_blank}, 32'd0);

    // Set 23:59 via set modes, then run to 23:59:58 and through midnight.
    pulse(1'b1, 1'b0);
    check_eq("mode_set_hour", {30'd0, bus.o_mode}, 32'd1);
    check_eq("enter_blank", {26'd0, bus.o_digit_blank}, 32'd0);
    for (int i = 0; i < 23; i++) pulse(1'b0, 1'b1);
    check_eq("set_hour_23", hms(), 32'h230010);
    pulse(1'b1, 1'b0);
    check_eq("mode_set_min", {30'd0, bus.o_mode}, 32'd2);
    for (int i = 0; i < 59; i++) pulse(1'b0, 1'b1);
    check_eq("set_min_59", hms(), 32'h235910);
    pulse(1'b1, 1'b0);
    check_eq("back_run_sec0", hms(), 32'h235900);
    check_eq("back_run_mode", {30'd0, bus.o_mode}, 32'd0);
    step(58 * 4);
    check_eq("time_235958", hms(), 32'h235958);
    check_eq("tick_at_58", {31'd0, bus.o_tick}, 32'd1);
    step(4);
    check_eq("time_235959", hms(), 32'h235959);
    step(4);
    check_eq("midnight", hms(), 32'h000000);
    check_eq("midnight_tick", {31'd0, bus.o_tick}, 32'd1);

    // Hour adjust: 25 increments wrap through 23 -> 00 and end at 01.
    step(12);
    check_eq("time_000003", hms(), 32'h000003);
    pulse(1'b1, 1'b0);
    t0 = tick_cnt;
    for (int i = 1; i <= 25; i++) begin
      pulse(1'b0, 1'b1);
      if (i == 1)  check_eq("hour_inc_1", {24'd0, bus.o_hour10, bus.o_hour0}, 32'h01);
      if (i == 24) check_eq("hour_wrap_00", {24'd0, bus.o_hour10, bus.o_hour0}, 32'h00);
    end
    check_eq("hour_after_25", hms(), 32'h010003);
    check_eq("set_no_ticks", tick_cnt - t0, 0);

    // Minute adjust wraps 59 -> 00 without carrying into hours.
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 59; i++) pulse(1'b0, 1'b1);
    check_eq("min_59", hms(), 32'h015903);
    pulse(1'b0, 1'b1);
    check_eq("min_wrap_no_carry", hms(), 32'h010003);
    pulse(1'b1, 1'b0);
    check_eq("run_sec_cleared", hms(), 32'h010000);
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      step(1);
      if (bus.o_tick === 1'b1) first = k;
    end
    check_eq("restart_first_tick", first, 4);
    check_eq("restart_time", hms(), 32'h010001);

    // Blink in SET_HOUR: three cycles visible, three blanked; i_inc shows the field at once.
    pulse(1'b1, 1'b0);
    check_eq("blink_enter", {26'd0, bus.o_digit_blank}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check_eq($sformatf("blink_k%0d", k), {26'd0, bus.o_digit_blank},
               (((k / 3) % 2) == 1) ? 32'h30 : 32'h00);
    end
    step(3);
    check_eq("blink_on_again", {26'd0, bus.o_digit_blank}, 32'h30);
    pulse(1'b0, 1'b1);
    check_eq("blink_inc_clear", {26'd0, bus.o_digit_blank}, 32'd0);
    check_eq("blink_inc_hour", {24'd0, bus.o_hour10, bus.o_hour0}, 32'h02);

    // Back to RUN; i_inc ignored there; i_mode wins over a coincident i_inc.
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check_eq("run_again_time", hms(), 32'h020000);
    pulse(1'b0, 1'b1);
    check_eq("run_inc_ignored", {24'd0, bus.o_hour10, bus.o_hour0}, 32'h02);
    pulse(1'b1, 1'b1);
    check_eq("both_mode", {30'd0, bus.o_mode}, 32'd1);
    check_eq("both_hour", {24'd0, bus.o_hour10, bus.o_hour0}, 32'h02);

    // SET_MIN blink mask, then asynchronous reset mid-mode.
    pulse(1'b1, 1'b0);
    step(3);
    check_eq("blink_min_mask", {26'd0, bus.o_digit_blank}, 32'h0C);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_time", hms(), 32'h000000);
    check_eq("async_rst_mode", {30'd0, bus.o_mode}, 32'd0);
    check_eq("async_rst_blank", {26'd0, bus.o_digit_blank}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
